// File: rtl/product_scan_unit_pkg.sv
// Shared constants, state encoding and width helper for the product memory scan unit.
package product_scan_unit_pkg;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = 8;

    // Smallest width that holds DEPTH full-scale entries without wrapping.
    function automatic int sum_width(input int depth, input int dw);
        return $clog2(depth * ((1 << dw) - 1) + 1);
    endfunction

    localparam int SW = sum_width(DEPTH, DW);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

endpackage

// File: rtl/product_scan_unit_if.sv
// Handshake, memory read port and result bus of the scan unit.
interface product_scan_unit_if;
    import product_scan_unit_pkg::*;

    logic          start;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [SW-1:0] sum;
    logic [DW-1:0] max_val;
    logic [AW-1:0] max_idx;
    logic [CW-1:0] nz_cnt;

    modport master (
        input  start, rd_data,
        output rd_addr, rd_en, busy, done, sum, max_val, max_idx, nz_cnt
    );

    modport slave (
        output start, rd_data,
        input  rd_addr, rd_en, busy, done, sum, max_val, max_idx, nz_cnt
    );

endinterface

// File: rtl/product_scan_unit_scan_stat_accum.sv
// Working accumulators for one scan: running sum, first-seen maximum and non-zero count.
module product_scan_unit_scan_stat_accum
    import product_scan_unit_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          smp_en,
    input  logic [AW-1:0] smp_addr,
    input  logic [DW-1:0] smp_data,
    output logic [SW-1:0] sum_nxt,
    output logic [DW-1:0] max_nxt,
    output logic [AW-1:0] idx_nxt,
    output logic [CW-1:0] nz_nxt
);

    logic [SW-1:0] sum_q, sum_d;
    logic [DW-1:0] max_q, max_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [CW-1:0] nz_q,  nz_d;

    always_comb begin
        sum_d = sum_q;
        max_d = max_q;
        idx_d = idx_q;
        nz_d  = nz_q;
        if (clr) begin
            sum_d = '0;
            max_d = '0;
            idx_d = '0;
            nz_d  = '0;
        end else if (smp_en) begin
            sum_d = sum_q + SW'(smp_data);
            // Strict compare: on ties the earlier (lower) address wins.
            if (smp_data > max_q) begin
                max_d = smp_data;
                idx_d = smp_addr;
            end
            if (smp_data != '0) begin
                nz_d = nz_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            max_q <= '0;
            idx_q <= '0;
            nz_q  <= '0;
        end else begin
            sum_q <= sum_d;
            max_q <= max_d;
            idx_q <= idx_d;
            nz_q  <= nz_d;
        end
    end

    // The top commits on the final sample edge, so it needs the post-sample values.
    assign sum_nxt = sum_d;
    assign max_nxt = max_d;
    assign idx_nxt = idx_d;
    assign nz_nxt  = nz_d;

endmodule

// File: rtl/product_scan_unit.sv
// Sweeps the product memory once per start request and publishes sum/max/argmax/non-zero count.
//   state   | meaning
//   ST_IDLE | waiting for start, rd_addr parked at 0
//   ST_SCAN | reading one address per cycle, accumulating
//   ST_DONE | one-cycle done pulse, results just committed
module product_scan_unit
    import product_scan_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    product_scan_unit_if.master        bus
);

    scan_state_e   state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [SW-1:0] sum_q,   sum_d;
    logic [DW-1:0] max_q,   max_d;
    logic [AW-1:0] idx_q,   idx_d;
    logic [CW-1:0] nz_q,    nz_d;

    logic          acc_clr;
    logic          acc_smp;
    logic          commit;
    logic [SW-1:0] acc_sum;
    logic [DW-1:0] acc_max;
    logic [AW-1:0] acc_idx;
    logic [CW-1:0] acc_nz;

    product_scan_unit_scan_stat_accum u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (acc_clr),
        .smp_en   (acc_smp),
        .smp_addr (addr_q),
        .smp_data (bus.rd_data),
        .sum_nxt  (acc_sum),
        .max_nxt  (acc_max),
        .idx_nxt  (acc_idx),
        .nz_nxt   (acc_nz)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        acc_clr = 1'b0;
        acc_smp = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                if (bus.start) begin
                    acc_clr = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                acc_smp = 1'b1;
                if (addr_q == AW'(DEPTH - 1)) begin
                    addr_d  = '0;
                    commit  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                addr_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sum_d = sum_q;
        max_d = max_q;
        idx_d = idx_q;
        nz_d  = nz_q;
        if (commit) begin
            sum_d = acc_sum;
            max_d = acc_max;
            idx_d = acc_idx;
            nz_d  = acc_nz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            sum_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            nz_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            nz_q    <= nz_d;
        end
    end

    assign bus.rd_addr = addr_q;
    assign bus.busy    = (state_q == ST_SCAN);
    assign bus.rd_en   = (state_q == ST_SCAN);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.sum     = sum_q;
    assign bus.max_val = max_q;
    assign bus.max_idx = idx_q;
    assign bus.nz_cnt  = nz_q;

endmodule
